// File: rtl/regfile_pkg.sv
// Shared definitions for the register file read unit.
//   RF_WIDTH    : data word width in bits
//   RF_DEPTH    : number of architectural registers
//   RF_AW       : register-number width (RF_DEPTH = 2**RF_AW)
//   RF_ZERO_REG : register number that is hardwired to zero
//   reg_num_t   : register number type
//   reg_word_t  : register data word type
package regfile_pkg;

  localparam int RF_WIDTH    = 32;
  localparam int RF_DEPTH    = 32;
  localparam int RF_AW       = 5;
  localparam int RF_ZERO_REG = 0;

  typedef logic [RF_AW-1:0]    reg_num_t;
  typedef logic [RF_WIDTH-1:0] reg_word_t;

endpackage : regfile_pkg

// File: rtl/regfile_rd_port.sv
// One handshaked, registered read port of the register file.
// The port holds a single output register (qv/q) that behaves as a
// two-state valid/empty stage:
//   EMPTY -> FULL  on grant
//   FULL  -> FULL  on grant with transfer, or on stall
//   FULL  -> EMPTY on transfer without grant
// Ports:
//   clk, clrn     : clock, asynchronous active-low reset
//   rreq, rn      : read request and register number from decode
//   rgnt          : request accepted this cycle (combinational)
//   qv, q         : output valid and data toward the operand latch
//   qrdy          : consumer ready
//   rdata         : storage word currently addressed by rn
//   we, wn, d     : write-port signals, used for same-cycle bypass
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int AW    = RF_AW
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             rreq,
  input  logic [AW-1:0]    rn,
  output logic             rgnt,
  output logic             qv,
  output logic [WIDTH-1:0] q,
  input  logic             qrdy,
  input  logic [WIDTH-1:0] rdata,
  input  logic             we,
  input  logic [AW-1:0]    wn,
  input  logic [WIDTH-1:0] d
);

  logic [WIDTH-1:0] rd_value;
  logic             transfer;

  // Grant depends only on the request, qv and qrdy; the write port
  // never stalls a read, so there is no path from we/d into rgnt.
  assign rgnt     = rreq & (~qv | qrdy);
  assign transfer = qv & qrdy;

  // NOTE: every output of an always_comb gets a default on entry so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    rd_value = rdata;
    if (rn == AW'(RF_ZERO_REG)) begin
      rd_value = '0;
    end else if (we && (wn == rn)) begin
      // Writer and reader on the same edge: the new value wins.
      rd_value = d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      qv <= 1'b0;
      q  <= '0;
    end else if (rgnt) begin
      qv <= 1'b1;
      q  <= rd_value;
    end else if (transfer) begin
      // Drain only: q keeps its last value while empty.
      qv <= 1'b0;
    end
  end

endmodule : regfile_rd_port

// File: rtl/regfile_rd_unit.sv
// Register file with one write port and two independent handshaked,
// registered read ports (1-cycle latency, write bypass, r0 == 0).
// Ports:
//   Clk, Clrn                  : clock, asynchronous active-low reset
//   We, Wn, D                  : writeback port
//   Rreq_a, Rn_a, Rgnt_a       : port A request / register / grant
//   Qv_a, Q_a, Qrdy_a          : port A output valid / data / ready
//   Rreq_b ... Qrdy_b          : same for port B
module regfile_rd_unit
  import regfile_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int DEPTH = RF_DEPTH,
  parameter int AW    = RF_AW
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic             We,
  input  logic [AW-1:0]    Wn,
  input  logic [WIDTH-1:0] D,
  input  logic             Rreq_a,
  input  logic [AW-1:0]    Rn_a,
  output logic             Rgnt_a,
  output logic             Qv_a,
  output logic [WIDTH-1:0] Q_a,
  input  logic             Qrdy_a,
  input  logic             Rreq_b,
  input  logic [AW-1:0]    Rn_b,
  output logic             Rgnt_b,
  output logic             Qv_b,
  output logic [WIDTH-1:0] Q_b,
  input  logic             Qrdy_b
);

  logic [WIDTH-1:0] regs [DEPTH];

  // NOTE: the storage array is cleared by reset because the register
  // file must read as zero after reset; this keeps it in flops rather
  // than a RAM macro, which is acceptable at 32 x 32.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (We && (Wn != AW'(RF_ZERO_REG))) begin
      regs[Wn] <= D;
    end
  end

  regfile_rd_port #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_port_a (
    .clk   (Clk),
    .clrn  (Clrn),
    .rreq  (Rreq_a),
    .rn    (Rn_a),
    .rgnt  (Rgnt_a),
    .qv    (Qv_a),
    .q     (Q_a),
    .qrdy  (Qrdy_a),
    .rdata (regs[Rn_a]),
    .we    (We),
    .wn    (Wn),
    .d     (D)
  );

  regfile_rd_port #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_port_b (
    .clk   (Clk),
    .clrn  (Clrn),
    .rreq  (Rreq_b),
    .rn    (Rn_b),
    .rgnt  (Rgnt_b),
    .qv    (Qv_b),
    .q     (Q_b),
    .qrdy  (Qrdy_b),
    .rdata (regs[Rn_b]),
    .we    (We),
    .wn    (Wn),
    .d     (D)
  );

endmodule : regfile_rd_unit

// File: tb/tb_regfile_rd_unit.sv
// Self-checking bench for regfile_rd_unit: reset state, full r0..r31
// sweep, dual-port read, bypass, r0 write discard, stall/hold, streaming
// with a toggling ready, and asynchronous reset mid-stream.
module tb_regfile_rd_unit;
  import regfile_pkg::*;

  logic      Clk;
  logic      Clrn;
  logic      We;
  reg_num_t  Wn;
  reg_word_t D;
  logic      Rreq_a, Rgnt_a, Qv_a, Qrdy_a;
  reg_num_t  Rn_a;
  reg_word_t Q_a;
  logic      Rreq_b, Rgnt_b, Qv_b, Qrdy_b;
  reg_num_t  Rn_b;
  reg_word_t Q_b;

  int tests;
  int fails;

  regfile_rd_unit dut (
    .Clk    (Clk),
    .Clrn   (Clrn),
    .We     (We),
    .Wn     (Wn),
    .D      (D),
    .Rreq_a (Rreq_a),
    .Rn_a   (Rn_a),
    .Rgnt_a (Rgnt_a),
    .Qv_a   (Qv_a),
    .Q_a    (Q_a),
    .Qrdy_a (Qrdy_a),
    .Rreq_b (Rreq_b),
    .Rn_b   (Rn_b),
    .Rgnt_b (Rgnt_b),
    .Qv_b   (Qv_b),
    .Q_b    (Q_b),
    .Qrdy_b (Qrdy_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic      we;
    reg_num_t  wn;
    reg_word_t d;
    logic      rreq_a;
    reg_num_t  rn_a;
    logic      qrdy_a;
    logic      rreq_b;
    reg_num_t  rn_b;
    logic      qrdy_b;
    logic      gnt_a;
    logic      gnt_b;
    logic      qv_a;
    reg_word_t q_a;
    logic      qv_b;
    reg_word_t q_b;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  function automatic vec_t mk(
    input logic we, input int wn, input reg_word_t d,
    input logic rreq_a, input int rn_a, input logic qrdy_a,
    input logic rreq_b, input int rn_b, input logic qrdy_b,
    input logic gnt_a, input logic gnt_b,
    input logic qv_a, input reg_word_t q_a,
    input logic qv_b, input reg_word_t q_b);
    vec_t v;
    v.we = we;         v.wn = reg_num_t'(wn);     v.d = d;
    v.rreq_a = rreq_a; v.rn_a = reg_num_t'(rn_a); v.qrdy_a = qrdy_a;
    v.rreq_b = rreq_b; v.rn_b = reg_num_t'(rn_b); v.qrdy_b = qrdy_b;
    v.gnt_a = gnt_a;   v.gnt_b = gnt_b;
    v.qv_a = qv_a;     v.q_a = q_a;
    v.qv_b = qv_b;     v.q_b = q_b;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input int wn, input reg_word_t d,
                       input logic rreq_a, input int rn_a, input logic qrdy_a,
                       input logic rreq_b, input int rn_b, input logic qrdy_b);
    We = we;         Wn = reg_num_t'(wn);     D = d;
    Rreq_a = rreq_a; Rn_a = reg_num_t'(rn_a); Qrdy_a = qrdy_a;
    Rreq_b = rreq_b; Rn_b = reg_num_t'(rn_b); Qrdy_b = qrdy_b;
  endtask

  // Advance one edge and land 1 time unit after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int   next_rn;
    int   recv;
    logic m_qv;
    logic exp_gnt;
    logic xfer;

    tests = 0;
    fails = 0;

    // Dual-port read, bypass, r0 discard, A stall/hold, B stall/drain.
    // Columns: we wn d | A rreq rn qrdy | B rreq rn qrdy |
    //          gnt_a gnt_b | qv_a q_a | qv_b q_b
    vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 1, 0, 0, 1, 0, 0, 0, 32'h0,        0, 32'h0);
    vecs[1]  = mk(0, 0, 32'h0,        1, 5, 1, 1, 5, 1, 1, 1, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF);
    vecs[2]  = mk(1, 7, 32'h12345678, 1, 7, 1, 1, 7, 1, 1, 1, 1, 32'h12345678, 1, 32'h12345678);
    vecs[3]  = mk(1, 0, 32'hFFFFFFFF, 1, 0, 1, 1, 0, 1, 1, 1, 1, 32'h0,        1, 32'h0);
    vecs[4]  = mk(0, 0, 32'h0,        1, 0, 1, 1, 7, 1, 1, 1, 1, 32'h0,        1, 32'h12345678);
    vecs[5]  = mk(1, 3, 32'h11,       0, 0, 1, 0, 0, 1, 0, 0, 0, 32'h0,        0, 32'h12345678);
    vecs[6]  = mk(0, 0, 32'h0,        1, 3, 1, 0, 0, 1, 1, 0, 1, 32'h11,       0, 32'h12345678);
    vecs[7]  = mk(1, 3, 32'h22,       1, 3, 0, 0, 0, 1, 0, 0, 1, 32'h11,       0, 32'h12345678);
    vecs[8]  = mk(0, 0, 32'h0,        1, 3, 0, 0, 0, 1, 0, 0, 1, 32'h11,       0, 32'h12345678);
    vecs[9]  = mk(0, 0, 32'h0,        1, 3, 0, 0, 0, 1, 0, 0, 1, 32'h11,       0, 32'h12345678);
    vecs[10] = mk(0, 0, 32'h0,        1, 3, 1, 0, 0, 1, 1, 0, 1, 32'h22,       0, 32'h12345678);
    vecs[11] = mk(0, 0, 32'h0,        0, 0, 1, 0, 0, 1, 0, 0, 0, 32'h22,       0, 32'h12345678);
    vecs[12] = mk(0, 0, 32'h0,        0, 0, 1, 1, 5, 0, 0, 1, 0, 32'h22,       1, 32'hDEADBEEF);
    vecs[13] = mk(0, 0, 32'h0,        0, 0, 1, 1, 7, 0, 0, 0, 0, 32'h22,       1, 32'hDEADBEEF);
    vecs[14] = mk(0, 0, 32'h0,        0, 0, 1, 0, 0, 1, 0, 0, 0, 32'h22,       0, 32'hDEADBEEF);

    // ---- reset ----
    Clrn = 1'b0;
    drive(0, 0, 32'h0, 0, 0, 1, 0, 0, 1);
    repeat (2) @(posedge Clk);
    #1;
    check("reset qv_a", 32'(Qv_a), 32'h0);
    check("reset q_a",  Q_a,       32'h0);
    check("reset qv_b", 32'(Qv_b), 32'h0);
    check("reset q_b",  Q_b,       32'h0);
    #2 Clrn = 1'b1;
    tick();

    // ---- sweep r0..r31 on port A after reset ----
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 32'h0, 1, i, 1, 0, 0, 1);
      #1;
      check($sformatf("sweep gnt_a r%0d", i), 32'(Rgnt_a), 32'h1);
      tick();
      check($sformatf("sweep qv_a r%0d", i), 32'(Qv_a), 32'h1);
      check($sformatf("sweep q_a r%0d", i),  Q_a,       32'h0);
      check($sformatf("sweep qv_b r%0d", i), 32'(Qv_b), 32'h0);
    end
    drive(0, 0, 32'h0, 0, 0, 1, 0, 0, 1);
    tick();
    check("sweep drain qv_a", 32'(Qv_a), 32'h0);

    // ---- table-driven vectors ----
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].we, int'(vecs[i].wn), vecs[i].d,
            vecs[i].rreq_a, int'(vecs[i].rn_a), vecs[i].qrdy_a,
            vecs[i].rreq_b, int'(vecs[i].rn_b), vecs[i].qrdy_b);
      #1;
      check($sformatf("vec%0d gnt_a", i), 32'(Rgnt_a), 32'(vecs[i].gnt_a));
      check($sformatf("vec%0d gnt_b", i), 32'(Rgnt_b), 32'(vecs[i].gnt_b));
      tick();
      check($sformatf("vec%0d qv_a", i), 32'(Qv_a), 32'(vecs[i].qv_a));
      check($sformatf("vec%0d q_a", i),  Q_a,       vecs[i].q_a);
      check($sformatf("vec%0d qv_b", i), 32'(Qv_b), 32'(vecs[i].qv_b));
      check($sformatf("vec%0d q_b", i),  Q_b,       vecs[i].q_b);
    end

    // ---- streaming r1..r8 with Qrdy_a toggling 1,0,1,0 ----
    for (int i = 1; i <= 8; i++) begin
      drive(1, i, reg_word_t'(i), 0, 0, 1, 0, 0, 1);
      tick();
    end
    drive(0, 0, 32'h0, 0, 0, 1, 0, 0, 1);
    tick();
    next_rn = 1;
    recv    = 0;
    m_qv    = 1'b0;
    for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
      drive(0, 0, 32'h0, next_rn <= 8, next_rn, (cyc % 2) == 0, 0, 0, 1);
      #1;
      exp_gnt = Rreq_a && (!m_qv || Qrdy_a);
      xfer    = m_qv && Qrdy_a;
      check($sformatf("stream c%0d gnt_a", cyc), 32'(Rgnt_a), 32'(exp_gnt));
      check($sformatf("stream c%0d qv_a", cyc),  32'(Qv_a),   32'(m_qv));
      if (xfer) begin
        recv++;
        check($sformatf("stream beat%0d q_a", recv), Q_a, 32'(recv));
      end
      tick();
      if (exp_gnt) begin
        next_rn++;
        m_qv = 1'b1;
      end else if (xfer) begin
        m_qv = 1'b0;
      end
    end
    check("stream beats received", 32'(recv), 32'd8);

    // ---- async reset mid-stream ----
    drive(0, 0, 32'h0, 1, 1, 0, 1, 2, 0);
    tick();
    check("pre-reset qv_a", 32'(Qv_a), 32'h1);
    check("pre-reset q_a",  Q_a,       32'h1);
    check("pre-reset q_b",  Q_b,       32'h2);
    #2 Clrn = 1'b0;
    #1;
    check("async rst qv_a", 32'(Qv_a), 32'h0);
    check("async rst q_a",  Q_a,       32'h0);
    check("async rst qv_b", 32'(Qv_b), 32'h0);
    check("async rst q_b",  Q_b,       32'h0);
    drive(0, 0, 32'h0, 0, 0, 1, 0, 0, 1);
    @(posedge Clk);
    #2 Clrn = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 32'h0, 1, i, 1, 1, 31 - i, 1);
      #1;
      check($sformatf("post-rst gnt_a r%0d", i), 32'(Rgnt_a), 32'h1);
      tick();
      check($sformatf("post-rst qv_a r%0d", i), 32'(Qv_a), 32'h1);
      check($sformatf("post-rst q_a r%0d", i),  Q_a,       32'h0);
      check($sformatf("post-rst q_b r%0d", 31 - i), Q_b,   32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_regfile_rd_unit
